// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one-deep sample buffer, mono sample sent in both slots.
// Define I2S_TX_MUTE_ON_UNDERRUN_EN to send silence instead of repeating on underrun.
module i2s_tx_serializer #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_W);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_N  = BW'(SLOT_W);

  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       bit_nxt;
  logic [BW-1:0]       slot_pos;
  logic [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0] frame_reg;
  logic                hold_full;
  logic                div_wrap;
  logic                fall;
  logic                wrap0;
  logic                accept;
  logic                starve;
  logic                sd_nxt;

  assign sample_ready = ~hold_full;

  assign div_wrap = (div_cnt == DIV_MAX);
  assign fall     = div_wrap & bclk;
  assign wrap0    = fall & (bit_cnt == BIT_MAX);
  assign accept   = sample_valid & ~hold_full;
  assign starve   = wrap0 & ~hold_full & ~sample_valid;

  assign bit_nxt = (bit_cnt == BIT_MAX) ? '0
                 : bit_cnt + BW'(1);

  assign slot_pos = (bit_nxt >= SLOT_N) ? bit_nxt - SLOT_N
                  : bit_nxt;

  // Slot position k carries bit SAMPLE_W-k; k=0 is the I2S one-bit delay
  always_comb begin
    sd_nxt = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (slot_pos == BW'(SAMPLE_W - i)) begin
        sd_nxt = frame_reg[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= BIT_MAX;
      bclk        <= 1'b0;
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      frame_reg   <= '0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= div_wrap ? '0 : div_cnt + DW'(1);

      if (div_wrap) begin
        bclk <= ~bclk;
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= SLOT_N);
        sdata   <= sd_nxt;
      end

      if (wrap0) begin
        frame_start <= 1'b1;
        if (hold_full) begin
          frame_reg <= hold;
          hold_full <= 1'b0;
        end else if (sample_valid) begin
          frame_reg <= sample_in;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        end else begin
          frame_reg <= '0;
`endif
        end
      end else if (accept) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end

      if (starve) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: time-based reference model plus an I2S receiver.
// Payload on underrun follows I2S_TX_MUTE_ON_UNDERRUN_EN like the design.
module tb_i2s_tx_serializer;

  localparam int CD    = 2;
  localparam int SW    = 16;
  localparam int SL    = 32;
  localparam int FRAME = 4 * SL * CD;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  localparam logic [15:0] UND_WORD = 16'h0000;
`else
  localparam logic [15:0] UND_WORD = 16'h1234;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          underrun_clr = 1'b0;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          frame_start;
  logic          underrun;

  always #5 clk = ~clk;

  i2s_tx_serializer #(
    .CLK_DIV  (CD),
    .SAMPLE_W (SW),
    .SLOT_W   (SL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // Reference model: edge count since release drives all timing
  int            n;
  bit            m_full, m_und, m_bclk, m_lr, m_sd, m_fs;
  logic [SW-1:0] m_hold, m_frame;

  // Monitors and receiver
  int            t_fs, t_lrf, t_r0, t_r1;
  bit            hs;
  logic          prev_lr;
  logic          rx_pb, rx_lr;
  int            rx_k;
  logic [15:0]   rx_w;
  logic [15:0]   rx_l[$];
  logic [15:0]   rx_r[$];

  function automatic bit is_fs(input int e);
    return e >= 2 * CD && (e - 2 * CD) % FRAME == 0;
  endfunction

  function automatic logic [15:0] last_of(input logic [15:0] q[$]);
    if (q.size() == 0) return 16'hxxxx;
    return q[q.size() - 1];
  endfunction

  task automatic tb_reset();
    n       = 0;
    m_full  = 0;
    m_und   = 0;
    m_bclk  = 0;
    m_lr    = 1;
    m_sd    = 0;
    m_fs    = 0;
    m_hold  = '0;
    m_frame = '0;
    prev_lr = 1'b1;
    rx_pb   = 1'b0;
    rx_lr   = 1'b1;
    rx_k    = 0;
    rx_w    = '0;
  endtask

  task automatic model_edge();
    bit fs, und_set;
    int m, b, k;
    n++;
    fs      = is_fs(n);
    und_set = 0;
    if (fs) begin
      if (m_full) begin
        m_frame = m_hold;
        m_full  = 0;
      end else if (sample_valid) begin
        m_frame = sample_in;
      end else begin
        und_set = 1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        m_frame = '0;
`endif
      end
    end else if (sample_valid && !m_full) begin
      m_hold = sample_in;
      m_full = 1;
    end
    if (und_set) m_und = 1;
    else if (underrun_clr) m_und = 0;
    m_fs   = fs;
    m_bclk = ((n / CD) % 2) == 1;
    if (n % (2 * CD) == 0) begin
      m    = n / (2 * CD);
      b    = (m - 1) % (2 * SL);
      k    = b % SL;
      m_lr = (b >= SL);
      m_sd = (k >= 1 && k <= SW) ? m_frame[SW - k] : 1'b0;
    end
  endtask

  task automatic rx_update();
    if (!rx_pb && bclk) begin
      if (lrclk !== rx_lr) begin
        rx_k  = 0;
        rx_lr = lrclk;
      end else begin
        rx_k++;
      end
      if (rx_k >= 1 && rx_k <= SW) rx_w = {rx_w[14:0], sdata};
      if (rx_k == SW) begin
        if (lrclk) rx_r.push_back(rx_w);
        else rx_l.push_back(rx_w);
      end
    end
    rx_pb = bclk;
  endtask

  task automatic step();
    hs = sample_valid && sample_ready;
    @(posedge clk);
    if (rst) tb_reset();
    else model_edge();
    #1;
    chk("bclk", bclk, m_bclk);
    chk("lrclk", lrclk, m_lr);
    chk("sdata", sdata, m_sd);
    chk("frame_start", frame_start, m_fs);
    chk("underrun", underrun, m_und);
    chk("sample_ready", sample_ready, !m_full);
    if (!rst) begin
      if (frame_start && t_fs < 0) t_fs = n;
      if (prev_lr && !lrclk && t_lrf < 0) t_lrf = n;
      if (!rx_pb && bclk) begin
        if (t_r0 < 0) t_r0 = n;
        else if (t_r1 < 0) t_r1 = n;
      end
    end
    prev_lr = lrclk;
    rx_update();
  endtask

  task automatic wait_fs();
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!frame_start && i < 2 * FRAME);
    if (!frame_start) chk("wait_fs_timeout", 0, 1);
  endtask

  task automatic step_to_fs();
    while (!is_fs(n + 1)) step();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bclk"}, bclk, 0);
    chk({tag, "_lrclk"}, lrclk, 1);
    chk({tag, "_sdata"}, sdata, 0);
    chk({tag, "_ready"}, sample_ready, 1);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_und"}, underrun, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] base, cur, e;
    int acc, k;
    t_fs  = -1;
    t_lrf = -1;
    t_r0  = -1;
    t_r1  = -1;
    tb_reset();
    #2 rst = 1'b1;
    #1 chk_reset_outs("rst");
    repeat (3) step();

    // Serialization of a sample offered before the first frame
    rst          = 1'b0;
    sample_in    = 16'hA5C3;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("a5c3_accept", hs, 1);
    while (n < 220) step();
    chk("first_fs", t_fs, 2 * CD);
    chk("first_lr_fall", t_lrf, 2 * CD);
    chk("bclk_period", t_r1 - t_r0, 2 * CD);
    chk("ser_nl", rx_l.size(), 1);
    chk("ser_nr", rx_r.size(), 1);
    chk("ser_left", last_of(rx_l), 16'hA5C3);
    chk("ser_right", last_of(rx_r), 16'hA5C3);

    // Backpressure with valid held high
    rx_l.delete();
    rx_r.delete();
    base         = 16'($urandom);
    cur          = base;
    sample_in    = cur;
    sample_valid = 1'b1;
    acc          = 0;
    while (n < 1400) begin
      step();
      if (frame_start) begin
        chk("acc_per_frame", acc, 1);
        acc = 0;
      end
      if (hs) begin
        acc++;
        cur++;
        sample_in = cur;
      end
    end
    sample_valid = 1'b0;
    chk("bp_nl", rx_l.size(), 5);
    for (int i = 0; i < rx_l.size(); i++) begin
      e = base + 16'(i);
      chk("bp_left", rx_l[i], e);
    end
    for (int i = 0; i < rx_r.size(); i++) begin
      e = base + 16'(i);
      chk("bp_right", rx_r[i], e);
    end

    // Bypass: offer only in the frame-start clk with hold empty
    wait_fs();
    step_to_fs();
    sample_in    = 16'h7FFF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("byp_hs", hs, 1);
    chk("byp_fs", frame_start, 1);
    chk("byp_und", underrun, 0);
    rx_l.delete();
    rx_r.delete();
    repeat (210) step();
    chk("byp_left", last_of(rx_l), 16'h7FFF);
    chk("byp_right", last_of(rx_r), 16'h7FFF);

    // Underrun after a single sample
    sample_in    = 16'h1234;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("und_accept", hs, 1);
    wait_fs();
    chk("und_pre", underrun, 0);
    wait_fs();
    chk("und_set", underrun, 1);
    rx_l.delete();
    rx_r.delete();
    repeat (210) step();
    chk("und_left", last_of(rx_l), UND_WORD);
    chk("und_right", last_of(rx_r), UND_WORD);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("und_clr", underrun, 0);
    step_to_fs();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("und_clr_fs", frame_start, 1);
    chk("und_set_wins", underrun, 1);

    // Reset at clk 100 of a frame with the holding register full
    repeat (98) step();
    sample_in    = 16'($urandom);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("mr_ready_lo", sample_ready, 0);
    rst = 1'b1;
    #1 chk_reset_outs("mr");
    tb_reset();
    repeat (2) step();
    rst = 1'b0;
    k   = 0;
    do begin
      step();
      k++;
    end while (!frame_start && k < 20);
    chk("mr_fs_delay", k, 2 * CD);
    chk("mr_underrun", underrun, 1);
    repeat (50) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
